// File: rtl/coco_bus_clkgen_if.sv
// Bus-timing bundle between the CoCo clock generator and its consumers.
// The generator takes the "master" side: it reads rate/addr and drives the phases and strobes.
interface coco_bus_clkgen_if;
  logic [1:0]  rate;
  logic [15:0] addr;
  logic        pix_ena;
  logic        e;
  logic        q;
  logic        e_rise;
  logic        e_fall;
  logic        q_rise;
  logic        cyc_fast;

  modport master (
    input  rate, addr,
    output pix_ena, e, q, e_rise, e_fall, q_rise, cyc_fast
  );

  modport slave (
    output rate, addr,
    input  pix_ena, e, q, e_rise, e_fall, q_rise, cyc_fast
  );
endinterface

// File: rtl/coco_bus_clkgen.sv
// CoCo system timing generator: pixel clock enable, 6809E E/Q quadrature phases with edge
// strobes, and SAM slow / address-dependent / fast rate selection latched at cycle boundaries.
module coco_bus_clkgen #(
  parameter int          PIX_DIV   = 4,
  parameter int          SLOW_DIV  = 16,
  parameter int          FAST_DIV  = 8,
  parameter logic [15:0] FAST_BASE = 16'h8000,
  parameter logic [15:0] IO_BASE   = 16'hFF00
) (
  input  logic               clk,
  input  logic               reset,
  coco_bus_clkgen_if.master  bus
);

  localparam int PCW = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
  localparam int PW  = $clog2(SLOW_DIV);
  localparam int LW  = PW + 1;

  localparam logic [PCW-1:0] PC_LAST = PCW'(PIX_DIV - 1);
  localparam logic [PCW-1:0] PC_ONE  = PCW'(1);
  localparam logic [PW-1:0]  PH_ONE  = PW'(1);
  localparam logic [LW-1:0]  LEN_ONE = LW'(1);
  localparam logic [LW-1:0]  SLOW_L  = LW'(SLOW_DIV);
  localparam logic [LW-1:0]  FAST_L  = LW'(FAST_DIV);

  logic [PCW-1:0] pc_r;
  logic           pix_ena_r;
  logic [PW-1:0]  ph_r;
  logic           cyc_fast_r;
  logic           e_r;
  logic           q_r;
  logic           e_rise_r;
  logic           e_fall_r;
  logic           q_rise_r;

  logic           rate_fast_s;
  logic [LW-1:0]  len_s;
  logic           wrap_s;
  logic [PW-1:0]  ph_next_s;
  logic           cyc_fast_next_s;
  logic           e_next_s;
  logic           q_next_s;

  // Rate decision for the cycle that would start at the next boundary.
  always_comb begin
    rate_fast_s = 1'b0;
    case (bus.rate)
      2'b00:   rate_fast_s = 1'b0;
      2'b01:   rate_fast_s = (bus.addr >= FAST_BASE) && (bus.addr < IO_BASE);
      default: rate_fast_s = 1'b1;
    endcase
  end

  // Phase counter advance and E/Q levels; the length stays fixed for the whole cycle, so a
  // rate change only takes effect from ph = 0 and never produces a runt phase.
  always_comb begin
    len_s           = cyc_fast_r ? FAST_L : SLOW_L;
    wrap_s          = ({1'b0, ph_r} == (len_s - LEN_ONE));
    ph_next_s       = ph_r;
    cyc_fast_next_s = cyc_fast_r;
    if (pix_ena_r) begin
      if (wrap_s) begin
        ph_next_s       = '0;
        cyc_fast_next_s = rate_fast_s;
      end else begin
        ph_next_s       = ph_r + PH_ONE;
        cyc_fast_next_s = cyc_fast_r;
      end
    end else begin
      ph_next_s       = ph_r;
      cyc_fast_next_s = cyc_fast_r;
    end
    e_next_s = ({1'b0, ph_next_s} >= (len_s >> 1));
    q_next_s = ({1'b0, ph_next_s} >= (len_s >> 2)) &&
               ({1'b0, ph_next_s} <  (len_s - (len_s >> 2)));
  end

  // Prescaler, phase state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r       <= '0;
      pix_ena_r  <= 1'b0;
      ph_r       <= '0;
      cyc_fast_r <= 1'b0;
      e_r        <= 1'b0;
      q_r        <= 1'b0;
      e_rise_r   <= 1'b0;
      e_fall_r   <= 1'b0;
      q_rise_r   <= 1'b0;
    end else begin
      pc_r       <= (pc_r == PC_LAST) ? '0 : (pc_r + PC_ONE);
      pix_ena_r  <= (pc_r == PC_LAST);
      ph_r       <= ph_next_s;
      cyc_fast_r <= cyc_fast_next_s;
      e_r        <= e_next_s;
      q_r        <= q_next_s;
      e_rise_r   <= e_next_s & ~e_r;
      e_fall_r   <= ~e_next_s & e_r;
      q_rise_r   <= q_next_s & ~q_r;
    end
  end

  assign bus.pix_ena  = pix_ena_r;
  assign bus.e        = e_r;
  assign bus.q        = q_r;
  assign bus.e_rise   = e_rise_r;
  assign bus.e_fall   = e_fall_r;
  assign bus.q_rise   = q_rise_r;
  assign bus.cyc_fast = cyc_fast_r;

endmodule

// File: tb/tb_coco_bus_clkgen.sv
// Directed bench for coco_bus_clkgen: table of {rate, addr, clk index, expected outputs}
// plus hand-written sequences for rate changes, mid-cycle reset and a random soak.
module tb_coco_bus_clkgen;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  coco_bus_clkgen_if bus ();

  coco_bus_clkgen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp bit order: {pix_ena, e, q, e_rise, e_fall, q_rise, cyc_fast}
  typedef struct {
    logic [1:0]  rate;
    logic [15:0] addr;
    int          n;
    logic [6:0]  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] outs();
    return {bus.pix_ena, bus.e, bus.q, bus.e_rise, bus.e_fall, bus.q_rise, bus.cyc_fast};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic add(input logic [1:0] r, input logic [15:0] a, input int n, input logic [6:0] x);
    vec_t v;
    v.rate = r; v.addr = a; v.n = n; v.exp = x;
    vecs.push_back(v);
  endtask

  // Holds reset for 5 clks with the given rate/addr; leaves reset asserted at a negedge.
  task automatic hold_reset(input logic [1:0] r, input logic [15:0] a);
    @(negedge clk);
    reset    = 1'b1;
    bus.rate = r;
    bus.addr = a;
    repeat (5) @(negedge clk);
  endtask

  // Counts clks until the chosen strobe (0 e_rise, 1 e_fall) is seen; cnt = -1 on timeout.
  task automatic wait_strobe(input int which, input int budget, output int cnt);
    cnt = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((which == 0) ? bus.e_rise : bus.e_fall) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    int   cnt;
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    bus.rate = 2'b00;
    bus.addr = 16'h0000;

    // Slow rate: pix_ena every 4 clks, E rises at 33, Q at 17, E period 64.
    add(2'b00, 16'h0000,  0, 7'b0000000);
    add(2'b00, 16'h0000,  1, 7'b0000000);
    add(2'b00, 16'h0000,  3, 7'b0000000);
    add(2'b00, 16'h0000,  4, 7'b1000000);
    add(2'b00, 16'h0000, 16, 7'b1000000);
    add(2'b00, 16'h0000, 17, 7'b0010010);
    add(2'b00, 16'h0000, 18, 7'b0010000);
    add(2'b00, 16'h0000, 32, 7'b1010000);
    add(2'b00, 16'h0000, 33, 7'b0111000);
    add(2'b00, 16'h0000, 48, 7'b1110000);
    add(2'b00, 16'h0000, 49, 7'b0100000);
    add(2'b00, 16'h0000, 64, 7'b1100000);
    add(2'b00, 16'h0000, 65, 7'b0000100);
    add(2'b00, 16'h0000, 81, 7'b0010010);
    // Fast rate: first cycle slow, then 32-clk cycles from clk 65.
    add(2'b10, 16'h0000, 64, 7'b1100000);
    add(2'b10, 16'h0000, 65, 7'b0000101);
    add(2'b10, 16'h0000, 73, 7'b0010011);
    add(2'b10, 16'h0000, 81, 7'b0111001);
    add(2'b10, 16'h0000, 89, 7'b0100001);
    add(2'b10, 16'h0000, 97, 7'b0000101);
    add(2'b11, 16'h0000, 65, 7'b0000101);
    // Address-dependent rate, including both window edges.
    add(2'b01, 16'h0400, 65, 7'b0000100);
    add(2'b01, 16'h0400, 81, 7'b0010010);
    add(2'b01, 16'hA000, 65, 7'b0000101);
    add(2'b01, 16'hA000, 81, 7'b0111001);
    add(2'b01, 16'hFF20, 65, 7'b0000100);
    add(2'b01, 16'h7FFF, 65, 7'b0000100);
    add(2'b01, 16'h8000, 65, 7'b0000101);
    add(2'b01, 16'hFEFF, 65, 7'b0000101);
    add(2'b01, 16'hFF00, 65, 7'b0000100);

    foreach (vecs[i]) begin
      hold_reset(vecs[i].rate, vecs[i].addr);
      if (vecs[i].n != 0) begin
        reset = 1'b0;
        repeat (vecs[i].n) @(negedge clk);
      end
      check($sformatf("vec%0d rate=%0b addr=%h n=%0d", i, vecs[i].rate, vecs[i].addr, vecs[i].n),
            int'(outs()), int'(vecs[i].exp));
    end

    // Address-dependent lengths: slow (0400), fast (A000), slow (FF20 set mid fast cycle).
    hold_reset(2'b01, 16'h0400);
    reset = 1'b0;
    wait_strobe(1, 200, cnt);
    check("rate01 first cycle", cnt, 65);
    check("rate01 cf after c1", int'(bus.cyc_fast), 0);
    bus.addr = 16'hA000;
    wait_strobe(1, 200, cnt);
    check("rate01 0400 cycle", cnt, 64);
    check("rate01 cf A000", int'(bus.cyc_fast), 1);
    bus.addr = 16'hFF20;
    wait_strobe(1, 200, cnt);
    check("rate01 A000 cycle", cnt, 32);
    check("rate01 cf FF20", int'(bus.cyc_fast), 0);
    wait_strobe(1, 200, cnt);
    check("rate01 FF20 cycle", cnt, 64);

    // Rate 00 -> 10 at ph=5: current cycle stays 64, following ones are 32.
    hold_reset(2'b00, 16'h0000);
    reset = 1'b0;
    repeat (22) @(negedge clk);
    bus.rate = 2'b10;
    wait_strobe(1, 200, cnt);
    check("toggle rest of slow", cnt, 43);
    check("toggle cf at boundary", int'(bus.cyc_fast), 1);
    wait_strobe(1, 200, cnt);
    check("toggle fast cycle1", cnt, 32);
    wait_strobe(1, 200, cnt);
    check("toggle fast cycle2", cnt, 32);

    // One-clk reset at ph=10 with E high: everything clears, no e_fall, timing restarts.
    hold_reset(2'b00, 16'h0000);
    reset = 1'b0;
    repeat (42) @(negedge clk);
    check("pre-reset e", int'(bus.e), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid reset outs", int'(outs()), 0);
    reset = 1'b0;
    wait_strobe(0, 200, cnt);
    check("restart e_rise", cnt, 33);
    wait_strobe(1, 200, cnt);
    check("restart e_fall", cnt, 32);

    // Random soak: strobes track level changes, Q leads E by L*PIX_DIV/4 clks.
    begin
      logic e_prev, q_prev;
      int   t, t_q, lead, cycles;
      logic [15:0] addr_set [4];
      addr_set[0] = 16'h0400; addr_set[1] = 16'hA000;
      addr_set[2] = 16'hFF20; addr_set[3] = 16'h8000;
      hold_reset(2'b00, 16'h0000);
      reset  = 1'b0;
      e_prev = 1'b0;
      q_prev = 1'b0;
      t      = 0;
      t_q    = 0;
      lead   = 16;
      cycles = 0;
      while (cycles < 1000 && t < 90000) begin
        @(negedge clk);
        t++;
        check("soak e_rise", int'(bus.e_rise), int'(bus.e & ~e_prev));
        check("soak e_fall", int'(bus.e_fall), int'(~bus.e & e_prev));
        check("soak q_rise", int'(bus.q_rise), int'(bus.q & ~q_prev));
        if (bus.q != q_prev) begin
          t_q  = t;
          lead = bus.cyc_fast ? 8 : 16;
        end
        if (bus.e != e_prev) check("soak q lead", t - t_q, lead);
        if (bus.e_fall) cycles++;
        e_prev = bus.e;
        q_prev = bus.q;
        if ($urandom_range(0, 30) == 0) begin
          bus.rate = 2'($urandom_range(0, 3));
          bus.addr = addr_set[$urandom_range(0, 3)];
        end
      end
      check("soak cycles", cycles, 1000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
